// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: mode encoding plus the
// PINGPONG direction and FILL phase state types.
package led_pattern_pkg;

   localparam logic [1:0] MODE_CHASE    = 2'd0;
   localparam logic [1:0] MODE_PINGPONG = 2'd1;
   localparam logic [1:0] MODE_FILL     = 2'd2;
   localparam logic [1:0] MODE_BLINK    = 2'd3;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   typedef enum logic {
      PH_FILLING  = 1'b0,
      PH_DRAINING = 1'b1
   } phase_e;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/display bundle of the LED pattern generator. The controller side
// (master) drives en/mode; the generator side (slave) drives led/tick.
interface led_pattern_gen_if #(
   parameter int N_LEDS = 8
);
   logic              en;
   logic [1:0]        mode;
   logic [N_LEDS-1:0] led;
   logic              tick;

   modport master (output en, output mode, input led, input tick);
   modport slave  (input en, input mode, output led, output tick);
endinterface

// File: rtl/tick_divider.sv
// Step-rate divider: counts enabled cycles and flags the cycle whose edge
// completes a period of TICK_DIV cycles. Holds while en is low; clr restarts
// the period. Reusable by the other display blocks.
module tick_divider #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic step
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_reg;

   // step is combinational so the consumer registers its update on the same
   // edge that wraps the count.
   assign step = en && (count_reg == LAST);

   // Period counter: cleared by reset/clr, advances only while enabled.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= (count_reg == LAST) ? '0 : count_reg + CNT_W'(1);
      end
   end
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: CHASE, PINGPONG, FILL and BLINK, one step
// every TICK_DIV enabled cycles, with a registered one-cycle step strobe.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int N_LEDS   = 8,
   parameter int TICK_DIV = 100_000_000,
   parameter int CNT_W    = $clog2(TICK_DIV)
) (
   input logic         clk,
   input logic         reset,
   led_pattern_gen_if.slave bus
);
   // A divide-by-one still needs a one-bit counter.
   localparam int DIV_W = (CNT_W < 1) ? 1 : CNT_W;

   logic [N_LEDS-1:0] led_reg, led_next;
   logic [1:0]        mode_reg;
   dir_e              dir_reg, dir_next;
   phase_e            phase_reg, phase_next;
   logic              tick_reg, tick_next;

   logic              mode_chg;
   logic              step;
   logic              onehot_ok;
   logic              fill_ok;
   logic [N_LEDS-2:0] fill_bit_ok;
   logic              go_left;
   logic [N_LEDS-1:0] shifted;

   function automatic logic [N_LEDS-1:0] init_pattern(input logic [1:0] m);
      case (m)
         MODE_FILL:  return '0;
         MODE_BLINK: return '1;
         default:    return {{(N_LEDS-1){1'b0}}, 1'b1};
      endcase
   endfunction

   assign mode_chg = (bus.mode != mode_reg);

   // A mode change also restarts the divider so the new pattern gets a full
   // first period.
   tick_divider #(
      .TICK_DIV (TICK_DIV),
      .CNT_W    (DIV_W)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (bus.en),
      .clr   (mode_chg),
      .step  (step)
   );

   // A legal FILL value is a thermometer code from bit 0: any lit bit must
   // have its lower neighbour lit as well.
   generate
      for (genvar gi = 0; gi < N_LEDS - 1; gi++) begin : g_fill_ok
         assign fill_bit_ok[gi] = led_reg[gi] | ~led_reg[gi+1];
      end
   endgenerate

   assign fill_ok   = &fill_bit_ok;
   assign onehot_ok = (led_reg != '0) && ((led_reg & (led_reg - 1'b1)) == '0);

   // Next pattern: mode change first (discards a coincident step), then step.
   always_comb begin
      led_next   = led_reg;
      dir_next   = dir_reg;
      phase_next = phase_reg;
      tick_next  = 1'b0;
      go_left    = 1'b0;
      shifted    = '0;
      if (mode_chg) begin
         led_next   = init_pattern(bus.mode);
         dir_next   = DIR_LEFT;
         phase_next = PH_FILLING;
      end else if (step) begin
         tick_next = 1'b1;
         case (mode_reg)
            MODE_CHASE: begin
               if (onehot_ok) led_next = {led_reg[N_LEDS-2:0], led_reg[N_LEDS-1]};
               else           led_next = init_pattern(MODE_CHASE);
            end
            MODE_PINGPONG: begin
               if (!onehot_ok) begin
                  led_next = init_pattern(MODE_PINGPONG);
                  dir_next = DIR_LEFT;
               end else begin
                  // The end LEDs force the direction, so each end shows once.
                  go_left = led_reg[0] | (~led_reg[N_LEDS-1] & (dir_reg == DIR_LEFT));
                  if (go_left) begin
                     shifted  = {led_reg[N_LEDS-2:0], 1'b0};
                     dir_next = shifted[N_LEDS-1] ? DIR_RIGHT : DIR_LEFT;
                  end else begin
                     shifted  = {1'b0, led_reg[N_LEDS-1:1]};
                     dir_next = shifted[0] ? DIR_LEFT : DIR_RIGHT;
                  end
                  led_next = shifted;
               end
            end
            MODE_FILL: begin
               if (!fill_ok) begin
                  led_next   = '0;
                  phase_next = PH_FILLING;
               end else if (phase_reg == PH_FILLING) begin
                  shifted    = {led_reg[N_LEDS-2:0], 1'b1};
                  phase_next = (&shifted) ? PH_DRAINING : PH_FILLING;
                  led_next   = shifted;
               end else begin
                  shifted    = {1'b0, led_reg[N_LEDS-1:1]};
                  phase_next = (shifted == '0) ? PH_FILLING : PH_DRAINING;
                  led_next   = shifted;
               end
            end
            default: led_next = ~led_reg;
         endcase
      end
   end

   // Pattern state registers; reset returns to CHASE with bit 0 lit.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_reg   <= init_pattern(MODE_CHASE);
         mode_reg  <= MODE_CHASE;
         dir_reg   <= DIR_LEFT;
         phase_reg <= PH_FILLING;
         tick_reg  <= 1'b0;
      end else begin
         led_reg   <= led_next;
         mode_reg  <= bus.mode;
         dir_reg   <= dir_next;
         phase_reg <= phase_next;
         tick_reg  <= tick_next;
      end
   end

   assign bus.led  = led_reg;
   assign bus.tick = tick_reg;
endmodule
